store_drain_queue: RTL and testbench

- In-order queue of retired stores, on the commit side of the out-of-order core.
- Accepts one retired store per cycle from ROB commit and holds it until written.
- Issues each store to data memory over a req/ack handshake, with byte strobes derived from RISC-V funct3 width.
- Flags when a younger load overlaps a not-yet-written store, so the load unit stalls instead of reading stale memory.

---
 rtl/core_pkg.sv | 22 ++
 rtl/store_drain_fsm.sv | 61 ++++++
 rtl/store_drain_queue.sv | 103 ++++++++++
 tb/tb_store_drain_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: funct3 width codes, store entry type and byte-lane helpers shared by the store queue and the load probe.
package core_pkg;
  localparam int ADDR_W = 32;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } store_entry_t;
  typedef enum logic {IDLE, BUSY} drain_state_t;
  function automatic logic lane_ok(input logic [2:0] w, input logic [1:0] a);
    return w == F3_SB || (w == F3_SH && !a[0]) || (w == F3_SW && a == 2'b00);
  endfunction
  function automatic logic [3:0] lane_strb(input logic [2:0] w, input logic [1:0] a);
    return w == F3_SB ? 4'b0001 << a : w == F3_SH ? 4'b0011 << a : w == F3_SW ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] lane_data(input logic [2:0] w, input logic [31:0] d);
    return w == F3_SB ? {4{d[7:0]}} : w == F3_SH ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/store_drain_fsm.sv
// store_drain_fsm: drives the head store onto the req/ack write port and pops it once acked.
module store_drain_fsm
  import core_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pending,
  input  logic          multi,
  input  logic [AW-1:0] head_addr,
  input  logic [31:0]   head_data,
  input  logic [3:0]    head_strb,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  output logic          pop
);
  drain_state_t state_q, state_d;
  logic          req_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   data_d;
  logic [3:0]    strb_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      mem_req   <= req_d;
      mem_addr  <= addr_d;
      mem_wdata <= data_d;
      mem_wstrb <= strb_d;
    end
  end
  // BUSY with req low is the reload cycle between back-to-back writes
  always_comb begin
    state_d = state_q;
    req_d   = mem_req;
    addr_d  = mem_addr;
    data_d  = mem_wdata;
    strb_d  = mem_wstrb;
    pop     = 1'b0;
    if (state_q == IDLE ? pending : !mem_req) begin
      state_d = BUSY;
      req_d   = 1'b1;
      addr_d  = head_addr;
      data_d  = head_data;
      strb_d  = head_strb;
    end else if (state_q == BUSY && mem_ack) begin
      pop     = 1'b1;
      req_d   = 1'b0;
      state_d = multi ? BUSY : IDLE;
    end
  end
endmodule

// File: rtl/store_drain_queue.sv
// store_drain_queue: in-order retired-store queue draining to data memory, with a load overlap probe.
// Define STORE_DRAIN_FORWARD_EN to add fwd_valid/fwd_data; load_hit then flags only partial overlaps.
module store_drain_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          commit_valid,
  input  logic [AW-1:0] commit_addr,
  input  logic [31:0]   commit_data,
  input  logic [2:0]    commit_width,
  output logic          commit_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ack,
  input  logic [AW-1:0] load_addr,
  input  logic [2:0]    load_width,
  output logic          load_hit,
  output logic          misalign_err,
  output logic          is_empty,
  output logic          is_full
`ifdef STORE_DRAIN_FORWARD_EN
  ,
  output logic          fwd_valid,
  output logic [31:0]   fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  store_entry_t  q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [IW-1:0] idx;
  logic [3:0]    ld_strb;
  logic          push, pop, any_hit, unused;
  assign count        = wr_ptr - rd_ptr;
  assign is_full      = wr_ptr[IW] != rd_ptr[IW] && wr_ptr[IW-1:0] == rd_ptr[IW-1:0];
  assign is_empty     = count == '0;
  assign commit_ready = !is_full;
  assign push         = commit_valid && commit_ready && lane_ok(commit_width, commit_addr[1:0]);
  assign ld_strb      = lane_strb({1'b0, load_width[1:0]}, load_addr[1:0]);
  assign unused       = load_width[2];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      misalign_err <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + PW'(push);
      rd_ptr       <= rd_ptr + PW'(pop);
      misalign_err <= commit_valid && commit_ready && !lane_ok(commit_width, commit_addr[1:0]);
    end
  end
  always_ff @(posedge clk) begin
    if (push)
      q[wr_ptr[IW-1:0]] <= '{addr: ADDR_W'({commit_addr[AW-1:2], 2'b00}),
                             data: lane_data(commit_width, commit_data),
                             strb: lane_strb(commit_width, commit_addr[1:0])};
  end
  store_drain_fsm #(.AW(AW)) u_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .pending   (!is_empty),
    .multi     (count > PW'(1)),
    .head_addr (q[rd_ptr[IW-1:0]].addr[AW-1:0]),
    .head_data (q[rd_ptr[IW-1:0]].data),
    .head_strb (q[rd_ptr[IW-1:0]].strb),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .pop       (pop)
  );
  // Walk oldest to youngest so the last match seen is the youngest store
  always_comb begin
    any_hit = 1'b0;
    idx     = '0;
`ifdef STORE_DRAIN_FORWARD_EN
    fwd_valid = 1'b0;
    fwd_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr[IW-1:0] + IW'(k);
      if (PW'(k) < count && q[idx].addr[AW-1:2] == load_addr[AW-1:2] && |(q[idx].strb & ld_strb)) begin
        any_hit = 1'b1;
`ifdef STORE_DRAIN_FORWARD_EN
        fwd_valid = (q[idx].strb & ld_strb) == ld_strb;
        fwd_data  = q[idx].data;
`endif
      end
    end
  end
`ifdef STORE_DRAIN_FORWARD_EN
  assign load_hit = any_hit && !fwd_valid;
`else
  assign load_hit = any_hit;
`endif
endmodule

// File: tb/tb_store_drain_queue.sv
// tb_store_drain_queue: directed self-checking bench for store_drain_queue (default build).
module tb_store_drain_queue;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [2:0]  commit_width;
  logic        commit_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] load_addr;
  logic [2:0]  load_width;
  logic        load_hit;
  logic        misalign_err;
  logic        is_empty;
  logic        is_full;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  store_drain_queue #(.DEPTH(8), .AW(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .commit_width (commit_width),
    .commit_ready (commit_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .load_addr    (load_addr),
    .load_width   (load_width),
    .load_hit     (load_hit),
    .misalign_err (misalign_err),
    .is_empty     (is_empty),
    .is_full      (is_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    commit_valid = 1'b1;
    commit_addr  = a;
    commit_data  = d;
    commit_width = w;
    step();
    commit_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 20 && !mem_req; i++) step();
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_wdata"}, mem_wdata, d);
    check({tag, "_wstrb"}, mem_wstrb, s);
  endtask

  initial begin
    reset_n = 1'b0; commit_valid = 1'b0; commit_addr = '0; commit_data = '0; commit_width = '0;
    mem_ack = 1'b0; load_addr = '0; load_width = '0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_empty", is_empty, 1);
    check("rst_full", is_full, 0);
    check("rst_ready", commit_ready, 1);
    check("rst_hit", load_hit, 0);
    check("rst_mis", misalign_err, 0);
    step();
    reset_n = 1'b1;
    step();
    // single SW, fixed two-cycle latency from commit to request
    mem_ack = 1'b1;
    commit(32'h100, 32'hDEADBEEF, 3'b010);
    check("sw_req_early", mem_req, 0);
    check("sw_nonempty", is_empty, 0);
    step();
    check("sw_req", mem_req, 1);
    check("sw_addr", mem_addr, 32'h100);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_wstrb", mem_wstrb, 4'b1111);
    step();
    check("sw_done", mem_req, 0);
    check("sw_empty", is_empty, 1);
    // byte and half lanes
    commit(32'h203, 32'h000000AB, 3'b000);
    expect_write("sb", 32'h200, 32'hABABABAB, 4'b1000);
    step();
    commit(32'h202, 32'h00001234, 3'b001);
    expect_write("sh", 32'h200, 32'h12341234, 4'b1100);
    step();
    check("sh_empty", is_empty, 1);
    // misaligned word and illegal width are dropped
    commit(32'h101, 32'h11111111, 3'b010);
    check("mis_sw_pulse", misalign_err, 1);
    check("mis_sw_empty", is_empty, 1);
    step();
    check("mis_sw_clear", misalign_err, 0);
    commit(32'h100, 32'h22222222, 3'b011);
    check("mis_w3_pulse", misalign_err, 1);
    step();
    check("mis_w3_clear", misalign_err, 0);
    step();
    check("mis_no_req", mem_req, 0);
    check("mis_empty", is_empty, 1);
    // fill to full with memory stalled
    mem_ack = 1'b0;
    commit_valid = 1'b1;
    commit_width = 3'b010;
    for (int i = 0; i < 8; i++) begin
      commit_addr = 32'h400 + 32'(4 * i);
      commit_data = 32'(i + 1);
      step();
    end
    commit_valid = 1'b0;
    check("fill_full", is_full, 1);
    check("fill_ready", commit_ready, 0);
    commit(32'h500, 32'h99, 3'b010);
    check("ninth_full", is_full, 1);
    check("ninth_ready", commit_ready, 0);
    load_addr = 32'h404; load_width = 3'b010; #1;
    check("full_probe_hit", load_hit, 1);
    load_addr = 32'h600; #1;
    check("full_probe_miss", load_hit, 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_write($sformatf("drain%0d", i), 32'h400 + 32'(4 * i), 32'(i + 1), 4'b1111);
      step();
    end
    check("drain_empty", is_empty, 1);
    step(); step(); step();
    check("drain_no_ninth", mem_req, 0);
    // load probe against a pending byte store
    mem_ack = 1'b0;
    commit(32'h300, 32'h00000055, 3'b000);
    load_addr = 32'h300; load_width = 3'b010; #1;
    check("probe_lw", load_hit, 1);
    load_addr = 32'h301; load_width = 3'b000; #1;
    check("probe_lb_other", load_hit, 0);
    load_addr = 32'h300; load_width = 3'b100; #1;
    check("probe_lbu", load_hit, 1);
    load_addr = 32'h304; load_width = 3'b010; #1;
    check("probe_next_word", load_hit, 0);
    commit(32'h304, 32'h1, 3'b010);
    commit(32'h308, 32'h2, 3'b010);
    check("busy_req", mem_req, 1);
    // asynchronous reset abandons the in-flight write
    #2 reset_n = 1'b0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_empty", is_empty, 1);
    check("arst_full", is_full, 0);
    step();
    reset_n = 1'b1;
    mem_ack = 1'b1;
    step();
    commit(32'h700, 32'hCAFEF00D, 3'b010);
    expect_write("post_rst", 32'h700, 32'hCAFEF00D, 4'b1111);
    step();
    check("post_rst_empty", is_empty, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
